// File: rtl/pmod_spi_rx_if.sv
// pmod_spi_rx_if: serial pins plus word handshake and status between SPI receiver and its driver/consumer
interface pmod_spi_rx_if #(
  parameter int WIDTH = 32
);
  logic             sck;
  logic             mosi;
  logic             csn;
  logic [WIDTH-1:0] word_data;
  logic             word_valid;
  logic             word_ready;
  logic             overrun;
  logic             frame_err;
  logic             clr_status;
  modport master (
    output sck, mosi, csn, word_ready, clr_status,
    input  word_data, word_valid, overrun, frame_err
  );
  modport slave (
    input  sck, mosi, csn, word_ready, clr_status,
    output word_data, word_valid, overrun, frame_err
  );
endinterface

// File: rtl/pmod_spi_rx.sv
// pmod_spi_rx: synchronises SPI pins, deserialises MSB-first words, presents them valid/ready with overrun and framing recovery
module pmod_spi_rx #(
  parameter int WIDTH        = 32,
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 2000
) (
  input logic          clk,
  input logic          rst_n,
  pmod_spi_rx_if.slave bus
);
  localparam int BW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {DESEL, IDLE, SHIFT} state_t;
  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, csn_sync;
  logic                   s_sck_d;
  logic [WIDTH-2:0]       shreg;
  logic [BW-1:0]          bit_cnt, bit_n;
  logic [15:0]            tmo_cnt, tmo_n;
  logic                   s_sck, s_mosi, s_csn, rise, shift, done, free, frame_err_n;
  assign s_sck  = sck_sync[SYNC_STAGES-1];
  assign s_mosi = mosi_sync[SYNC_STAGES-1];
  assign s_csn  = csn_sync[SYNC_STAGES-1];
  assign rise   = s_sck & ~s_sck_d;
  assign free   = ~bus.word_valid | bus.word_ready;
  // Framing FSM: deselect and idle timeout discard partial words, every sck rise shifts one bit
  always_comb begin
    state_n     = state;
    bit_n       = bit_cnt;
    frame_err_n = 1'b0;
    done        = 1'b0;
    shift       = 1'b0;
    tmo_n       = (rise || state != SHIFT) ? '0 : (tmo_cnt == 16'hFFFF ? tmo_cnt : tmo_cnt + 16'd1);
    if (s_csn) begin
      state_n     = DESEL;
      bit_n       = '0;
      frame_err_n = bit_cnt != '0;
    end else if (state == DESEL) begin
      state_n = IDLE;
    end else if (rise) begin
      shift   = 1'b1;
      done    = state == SHIFT && bit_cnt == BW'(WIDTH - 1);
      bit_n   = done ? '0 : bit_cnt + 1'b1;
      state_n = done ? IDLE : SHIFT;
    end else if (state == SHIFT && tmo_cnt == 16'(IDLE_TIMEOUT)) begin
      bit_n       = '0;
      state_n     = IDLE;
      frame_err_n = 1'b1;
    end
  end
  // Synchronisers, FSM state, shift register and the output holding register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_sync       <= '0;
      mosi_sync      <= '0;
      csn_sync       <= '0;
      s_sck_d        <= 1'b0;
      state          <= DESEL;
      bit_cnt        <= '0;
      tmo_cnt        <= '0;
      shreg          <= '0;
      bus.word_data  <= '0;
      bus.word_valid <= 1'b0;
      bus.overrun    <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      sck_sync      <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      mosi_sync     <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      csn_sync      <= {csn_sync[SYNC_STAGES-2:0], bus.csn};
      s_sck_d       <= s_sck;
      state         <= state_n;
      bit_cnt       <= bit_n;
      tmo_cnt       <= tmo_n;
      bus.frame_err <= frame_err_n;
      if (shift) shreg <= {shreg[WIDTH-3:0], s_mosi};
      if (done && free) begin
        bus.word_data  <= {shreg, s_mosi};
        bus.word_valid <= 1'b1;
      end else if (bus.word_ready) begin
        bus.word_valid <= 1'b0;
      end
      bus.overrun <= (done & ~free) | (bus.overrun & ~bus.clr_status);
    end
  end
endmodule

// File: tb/tb_pmod_spi_rx.sv
// tb_pmod_spi_rx: directed scenarios for the SPI word receiver with hand-computed expected words and status
module tb_pmod_spi_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pmod_spi_rx_if #(.WIDTH(32)) bus();
  pmod_spi_rx dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int errors = 0;
  int checks = 0;
  int valid_cycles = 0;
  int fe_cnt = 0;
  logic [31:0] got[$];
  // Event monitor: counts valid cycles and frame_err pulses, records accepted words
  always @(negedge clk) begin
    if (bus.word_valid === 1'b1) valid_cycles++;
    if (bus.frame_err === 1'b1) fe_cnt++;
    if (bus.word_valid === 1'b1 && bus.word_ready === 1'b1) got.push_back(bus.word_data);
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_bits(input logic [31:0] d, input int n, input int half);
    for (int i = n - 1; i >= 0; i--) begin
      bus.mosi = d[i];
      step(half);
      bus.sck = 1'b1;
      step(half);
      bus.sck = 1'b0;
    end
  endtask
  task automatic test_reset;
    bus.sck = 0; bus.mosi = 0; bus.csn = 0; bus.word_ready = 1; bus.clr_status = 0;
    rst_n = 0;
    step(3);
    checks++; if (bus.word_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.word_data); end
    checks++; if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.word_valid); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); end
    rst_n = 1;
    step(3);
    checks++; if (bus.word_valid !== 1'b0 || bus.frame_err !== 1'b0) begin errors++; $display("FAIL post_reset_idle: valid %b ferr %b want 0 0", bus.word_valid, bus.frame_err); end
  endtask
  task automatic test_single;
    int v0 = valid_cycles;
    got.delete();
    send_bits(32'hDEADBEEF, 32, 250);
    step(10);
    checks++; if (bus.word_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", bus.word_data); end
    checks++; if (valid_cycles - v0 != 1) begin errors++; $display("FAIL single_valid_len: got %0d want 1", valid_cycles - v0); end
    checks++; if (got.size() != 1) begin errors++; $display("FAIL single_accepts: got %0d want 1", got.size()); end
  endtask
  task automatic test_stream;
    int v0 = valid_cycles;
    int f0 = fe_cnt;
    got.delete();
    send_bits(32'hA5A5A5A5, 32, 10);
    send_bits(32'h12345678, 32, 10);
    step(10);
    checks++; if (got.size() != 2 || got[0] !== 32'hA5A5A5A5 || got[1] !== 32'h12345678) begin errors++; $display("FAIL stream_words: got %0d words want a5a5a5a5,12345678", got.size()); end
    checks++; if (valid_cycles - v0 != 2) begin errors++; $display("FAIL stream_valid_cycles: got %0d want 2", valid_cycles - v0); end
    checks++; if (fe_cnt != f0) begin errors++; $display("FAIL stream_frame_err: got %0d want 0", fe_cnt - f0); end
  endtask
  task automatic test_overrun;
    bus.word_ready = 0;
    got.delete();
    send_bits(32'hA5A5A5A5, 32, 10);
    step(10);
    checks++; if (bus.word_valid !== 1'b1 || bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_first: valid %b overrun %b want 1 0", bus.word_valid, bus.overrun); end
    send_bits(32'h12345678, 32, 10);
    step(10);
    checks++; if (bus.word_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL ovr_data_held: got %h want a5a5a5a5", bus.word_data); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", bus.overrun); end
    bus.word_ready = 1;
    step(1);
    bus.word_ready = 0;
    step(2);
    checks++; if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop: got %b want 0", bus.word_valid); end
    checks++; if (got.size() != 1 || bus.word_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL ovr_accept: accepts %0d data %h want 1 a5a5a5a5", got.size(), bus.word_data); end
    bus.clr_status = 1;
    step(1);
    bus.clr_status = 0;
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", bus.overrun); end
    bus.word_ready = 1;
  endtask
  task automatic test_csn_abort;
    int f0 = fe_cnt;
    send_bits(32'h000002AB, 10, 10);
    step(5);
    bus.csn = 1;
    step(10);
    checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL csn_frame_err: got %0d pulses want 1", fe_cnt - f0); end
    bus.csn = 0;
    step(5);
    got.delete();
    send_bits(32'h0F0F0F0F, 32, 10);
    step(10);
    checks++; if (got.size() != 1 || bus.word_data !== 32'h0F0F0F0F) begin errors++; $display("FAIL csn_realign: accepts %0d data %h want 1 0f0f0f0f", got.size(), bus.word_data); end
    checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL csn_frame_err_total: got %0d want 1", fe_cnt - f0); end
  endtask
  task automatic test_timeout;
    int f0 = fe_cnt;
    send_bits(32'h00000ABC, 12, 10);
    step(2000 + 10);
    checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL tmo_frame_err: got %0d pulses want 1", fe_cnt - f0); end
    got.delete();
    send_bits(32'hCAFEF00D, 32, 10);
    step(10);
    checks++; if (got.size() != 1 || bus.word_data !== 32'hCAFEF00D) begin errors++; $display("FAIL tmo_realign: accepts %0d data %h want 1 cafef00d", got.size(), bus.word_data); end
    checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL tmo_frame_err_total: got %0d want 1", fe_cnt - f0); end
  endtask
  task automatic test_mid_reset;
    int f0 = fe_cnt;
    send_bits(32'h000ABCDE, 20, 10);
    rst_n = 0;
    step(1);
    checks++; if (bus.word_data !== 32'h0 || bus.word_valid !== 1'b0 || bus.overrun !== 1'b0 || bus.frame_err !== 1'b0) begin errors++; $display("FAIL midrst_outputs: data %h valid %b ovr %b ferr %b want all 0", bus.word_data, bus.word_valid, bus.overrun, bus.frame_err); end
    rst_n = 1;
    step(5);
    checks++; if (fe_cnt != f0) begin errors++; $display("FAIL midrst_frame_err: got %0d want 0", fe_cnt - f0); end
    got.delete();
    send_bits(32'h80000001, 32, 10);
    step(10);
    checks++; if (got.size() != 1 || bus.word_data !== 32'h80000001) begin errors++; $display("FAIL midrst_word: accepts %0d data %h want 1 80000001", got.size(), bus.word_data); end
  endtask
  task automatic test_clr_vs_overrun;
    bus.word_ready = 0;
    send_bits(32'h11111111, 32, 10);
    step(10);
    checks++; if (bus.word_valid !== 1'b1 || bus.overrun !== 1'b0) begin errors++; $display("FAIL setwin_first: valid %b overrun %b want 1 0", bus.word_valid, bus.overrun); end
    send_bits(32'h22222222 >> 1, 31, 10);
    bus.mosi = 1'b0;
    step(10);
    bus.sck = 1'b1;
    step(2);
    bus.clr_status = 1;
    step(1);
    bus.clr_status = 0;
    step(10);
    bus.sck = 1'b0;
    step(5);
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL setwin_overrun: got %b want 1", bus.overrun); end
    checks++; if (bus.word_data !== 32'h11111111) begin errors++; $display("FAIL setwin_data: got %h want 11111111", bus.word_data); end
    bus.word_ready = 1;
    step(3);
  endtask
  initial begin
    test_reset;
    test_single;
    test_stream;
    test_overrun;
    test_csn_abort;
    test_timeout;
    test_mid_reset;
    test_clr_vs_overrun;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
